// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-register taps and memory handshake seen by the hazard controller,
// plus the stall/flush/forward controls it drives back into the pipeline.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0]       ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
  logic             regwrite_m, regwrite_w, memtoreg_e, branch_taken_e;
  logic             mem_req_m, mem_ready;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic [1:0]       forward_ae, forward_be;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
    output regwrite_m, regwrite_w, memtoreg_e, branch_taken_e, mem_req_m, mem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    input  forward_ae, forward_be, mem_timeout, stall_count
  );

  modport slave (
    input  ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
    input  regwrite_m, regwrite_w, memtoreg_e, branch_taken_e, mem_req_m, mem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    output forward_ae, forward_be, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage ARM pipeline: forwarding, load-use
// and branch handling, bounded memory waits. Optional feature macro: HAZARD_FWD_EN.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int            WW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t           state;
  logic [WW-1:0]    wait_cnt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             ldstall, memwait;
  logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

  // R15 is the PC and is never a forwarding or hazard source.
  function automatic logic hit(logic [3:0] a, logic [3:0] b);
    return (a == b) && (a != 4'd15);
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(logic [3:0] ra, logic rw_m, logic [3:0] wm,
                                         logic rw_w, logic [3:0] ww);
    if (rw_m && hit(ra, wm))      return 2'b10;
    else if (rw_w && hit(ra, ww)) return 2'b01;
    else                          return 2'b00;
  endfunction

  assign bus.forward_ae = fwd_sel(bus.ra1e, bus.regwrite_m, bus.wa3m, bus.regwrite_w, bus.wa3w);
  assign bus.forward_be = fwd_sel(bus.ra2e, bus.regwrite_m, bus.wa3m, bus.regwrite_w, bus.wa3w);
  assign ldstall = bus.memtoreg_e && (hit(bus.ra1d, bus.wa3e) || hit(bus.ra2d, bus.wa3e));
`else
  // Without bypass paths every Execute instruction is assumed to write wa3e,
  // and Decode waits until the producer has left Memory.
  logic unused_fwd;
  assign unused_fwd     = ^{bus.ra1e, bus.ra2e, bus.wa3w, bus.regwrite_w, bus.memtoreg_e};
  assign bus.forward_ae = 2'b00;
  assign bus.forward_be = 2'b00;
  assign ldstall = hit(bus.ra1d, bus.wa3e) || hit(bus.ra2d, bus.wa3e) ||
                   (bus.regwrite_m && (hit(bus.ra1d, bus.wa3m) || hit(bus.ra2d, bus.wa3m)));
`endif

  assign memwait = bus.mem_req_m && !bus.mem_ready;

  always_comb begin
    {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w} = '0;
    unique case (state)
      RUN: begin
        if (memwait)                 {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
        else if (bus.branch_taken_e) {flush_d, flush_e} = '1;
        else if (ldstall)            {stall_f, stall_d, flush_e} = '1;
      end
      MEMWAIT: begin
        // On timeout the access is dropped: pipeline released, Writeback bubbled.
        if (!bus.mem_ready) begin
          if (wait_cnt == WAIT_LAST) flush_w = 1'b1;
          else                       {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall_d && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      unique case (state)
        RUN: if (memwait) begin
          state    <= MEMWAIT;
          wait_cnt <= '0;
        end
        MEMWAIT: begin
          if (bus.mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= RUN;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.stall_f     = stall_f;
  assign bus.stall_d     = stall_d;
  assign bus.stall_e     = stall_e;
  assign bus.stall_m     = stall_m;
  assign bus.flush_d     = flush_d;
  assign bus.flush_e     = flush_e;
  assign bus.flush_w     = flush_w;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_count = stall_cnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage ARM pipeline (Fetch, Decode, Execute, Memory, Writeback).
- Inputs: register addresses and control bits from the stage registers, plus the data-memory/camera-buffer handshake.
- Outputs: per-stage stall and flush enables for the pipeline registers, and Execute-stage forwarding selects.
- Sequences multi-cycle memory waits with a bounded wait counter, and keeps a saturating stall-cycle statistic.

## Interface
Parameters:
- MAX_WAIT, 16: maximum cycles spent in MEMWAIT before abandoning the access.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ra1d, ra2d  in  4  source register addresses in Decode.
- ra1e, ra2e  in  4  source register addresses in Execute.
- wa3e, wa3m, wa3w  in  4  destination register in Execute, Memory and Writeback.
- regwrite_m, regwrite_w  in  1  destination write enable in Memory and Writeback.
- memtoreg_e  in  1  instruction in Execute is a load.
- branch_taken_e  in  1  branch or PC write resolved taken in Execute.
- mem_req_m  in  1  Memory stage issues an access this cycle.
- mem_ready  in  1  memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding pipeline register.
- flush_d, flush_e, flush_w  out  1  load a bubble (all zeros) into the register.
- forward_ae, forward_be  out  2  operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- mem_timeout  out  1  sticky flag: a memory access timed out.
- stall_count  out  CNT_W  saturating count of cycles with stall_d = 1.

## Operation
- FSM states: RUN, MEMWAIT.
- Register 15 (PC) never matches in forwarding or hazard compares.

Forwarding (combinational):
- forward_ae = 10 if regwrite_m and wa3m == ra1e.
- Otherwise forward_ae = 01 if regwrite_w and wa3w == ra1e.
- Otherwise forward_ae = 00.
- forward_be uses the same rules with ra2e.

Load-use hazard:
- ldstall = memtoreg_e and (wa3e == ra1d or wa3e == ra2d).
- In RUN, ldstall drives stall_f = stall_d = 1 and flush_e = 1.

Branch:
- In RUN, branch_taken_e drives flush_d = flush_e = 1.
- stall_f = 0 on a branch, so the new PC is fetched.
- Branch takes priority over ldstall: the stall terms are suppressed and flush_e stays 1.

Memory wait:
- In RUN, mem_req_m and not mem_ready gives memwait.
- memwait asserts stall_f, stall_d, stall_e, stall_m and flush_w in the same cycle, overriding the load-use and branch outputs.
- The FSM enters MEMWAIT at the next edge.
- In MEMWAIT, all four stalls and flush_w are asserted until mem_ready = 1.
- When mem_ready = 1, all stalls and flush_w drop combinationally in that cycle, and the FSM returns to RUN.
- Branch and load-use inputs are frozen during MEMWAIT and take effect in the first RUN cycle.

Wait counter:
- wait_cnt clears on entry to MEMWAIT and increments each MEMWAIT cycle.
- If wait_cnt == MAX_WAIT-1 and mem_ready = 0:
  - mem_timeout is set and holds until rst.
  - The FSM returns to RUN.
  - In that cycle the stalls deassert and flush_w = 1, so the access is dropped.

stall_count:
- Increments on every cycle with stall_d = 1.
- Saturates at 2^CNT_W - 1.

## Timing
- Reset values:
  - State RUN; wait_cnt 0; mem_timeout 0; stall_count 0.
  - All stall and flush outputs 0 while no hazard inputs are active; forward selects 00.
- Stall, flush and forward outputs are combinational from the current state and inputs, with zero-cycle latency.
- State, wait_cnt, mem_timeout and stall_count update on the rising clk edge.
- mem_ready asserted in the same cycle as mem_req_m: no stall, no state change.
- rst asserted mid-MEMWAIT: immediate return to RUN with counters cleared; outputs follow the reset values asynchronously.

## Configuration
- HAZARD_FWD_EN defined: forwarding operates as described above.
- HAZARD_FWD_EN undefined:
  - forward_ae and forward_be are tied to 00.
  - ldstall extends to any Decode source matching wa3e (with regwrite_e taken as memtoreg_e or an implied ALU write) or wa3m (with regwrite_m).
  - Decode is stalled and Execute flushed until the producer has left Memory.
  - The remaining behaviour is unchanged.

## Test plan
- Forwarding priority: regwrite_m = 1, wa3m = 3, regwrite_w = 1, wa3w = 3, ra1e = 3 -> forward_ae = 10. Repeat with wa3m = 15, ra1e = 15 -> 00.
- Load-use: memtoreg_e = 1, wa3e = 5, ra2d = 5 -> stall_f = stall_d = flush_e = 1 for one cycle. stall_count increments by 1.
- Branch plus load-use in the same cycle -> flush_d = flush_e = 1, stall_f = stall_d = 0.
- Memory wait: mem_req_m = 1 with mem_ready low for 3 cycles, then high:
  - All stalls are high for 3 cycles and low in the ready cycle.
  - A branch held during the wait flushes in the next cycle.
- Timeout with MAX_WAIT = 4 and mem_ready never asserted -> stalls for 4 cycles, then mem_timeout = 1 and state RUN. mem_timeout remains 1 until rst.
- rst pulse in the 2nd MEMWAIT cycle -> stalls 0 immediately, and stall_count = 0.
